// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Drives every datapath control line from the registered state; only jumps look at the flags.
module control_unit #(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [2:0]       IR,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             Enter,
    output logic             IRload,
    output logic             JMPmux,
    output logic             PCload,
    output logic             Meminst,
    output logic             MemWr,
    output logic             Aload,
    output logic             Sub,
    output logic [1:0]       Asel,
    output logic             Halt,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_LOAD    = 4'd3,
        S_STORE   = 4'd4,
        S_ADD     = 4'd5,
        S_SUB     = 4'd6,
        S_IN_WAIT = 4'd7,
        S_IN_REL  = 4'd8,
        S_JZ      = 4'd9,
        S_JPOS    = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    // Plain vector so the unused codes 12-15 stay representable and recoverable.
    logic [3:0]       r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_START;
            r_retired <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        IRload   = 1'b0;
        JMPmux   = 1'b0;
        PCload   = 1'b0;
        Meminst  = 1'b0;
        MemWr    = 1'b0;
        Aload    = 1'b0;
        Sub      = 1'b0;
        Asel     = 2'b00;
        Halt     = 1'b0;
        w_retire = 1'b0;
        w_next   = S_START;

        case (r_state)
            S_START: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                case (IR)
                    3'b000:  w_next = S_LOAD;
                    3'b001:  w_next = S_STORE;
                    3'b010:  w_next = S_ADD;
                    3'b011:  w_next = S_SUB;
                    3'b100:  w_next = S_IN_WAIT;
                    3'b101:  w_next = S_JZ;
                    3'b110:  w_next = S_JPOS;
                    default: begin
                        w_next   = S_HALT;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_LOAD: begin
                Meminst  = 1'b1;
                Asel     = 2'b10;
                Aload    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_STORE: begin
                Meminst  = 1'b1;
                MemWr    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADD: begin
                Meminst  = 1'b1;
                Aload    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_SUB: begin
                Meminst  = 1'b1;
                Sub      = 1'b1;
                Aload    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_IN_WAIT: begin
                if (Enter) begin
                    Asel   = 2'b01;
                    Aload  = 1'b1;
                    w_next = S_IN_REL;
                end else begin
                    w_next = S_IN_WAIT;
                end
            end
            S_IN_REL: begin
                // Wait for key release so one press loads exactly one value.
                if (Enter) begin
                    w_next = S_IN_REL;
                end else begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_JZ: begin
                JMPmux   = Aeq0;
                PCload   = Aeq0;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JPOS: begin
                JMPmux   = Apos;
                PCload   = Apos;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                Halt   = 1'b1;
                w_next = S_HALT;
            end
            default: begin
                w_next = S_START;
            end
        endcase
    end

    assign State   = r_state;
    assign Retired = r_retired;

    a_mem_excl: assert property (@(posedge Clock) disable iff (Reset) !(MemWr && Aload));
    a_irload_fetch: assert property (@(posedge Clock) disable iff (Reset)
        IRload |-> (r_state == S_FETCH));

endmodule
